hpt_status_decoder: RTL

Receiving end of the HPT-axis status bus. Samples the 8-bit status word `{state[2:0], response[1:0], FRH, FSH, T3_T4}` and the 10-bit one-hot image word produced by the hypothyroidism cycle. It turns state changes into timestamped transition records and queues them in a small FIFO. Downstream display and logging logic drains the records over a valid/ready handshake.

---
 rtl/hpt_pkg.sv | 54 +++++
 rtl/hpt_evt_fifo.sv | 50 +++++
 rtl/hpt_status_decoder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hpt_pkg.sv
// Shared codes, helper functions and record header type for the HPT status bus decoder.
package hpt_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL          = 3'd0,
    ST_TRIGGERED       = 3'd1,
    ST_ACTIVE_HYPO     = 3'd2,
    ST_ACTIVE_PIT      = 3'd3,
    ST_NO_THYROID      = 3'd4,
    ST_MEDICATED       = 3'd5,
    ST_REESTABLISHMENT = 3'd6,
    ST_ILLEGAL         = 3'd7
  } hpt_state_e;

  localparam logic [1:0] RESP_HEALTHY = 2'b00;
  localparam logic [1:0] RESP_LOW     = 2'b01;

  localparam logic [9:0] IMG_NORMAL          = 10'h001;
  localparam logic [9:0] IMG_TRIGGERED       = 10'h002;
  localparam logic [9:0] IMG_ACTIVE_HYPO     = 10'h004;
  localparam logic [9:0] IMG_ACTIVE_PIT      = 10'h008;
  localparam logic [9:0] IMG_NO_THYROID      = 10'h040;
  localparam logic [9:0] IMG_MEDICATED       = 10'h080;
  localparam logic [9:0] IMG_REESTABLISHMENT = 10'h020;
  localparam logic [9:0] IMG_NONE            = 10'h000;

  // Dwell is appended at the top level because its width is a module parameter.
  typedef struct packed {
    logic [2:0] from_state;
    logic [2:0] to_state;
  } hpt_evt_t;

  function automatic logic [9:0] state_to_image(input logic [2:0] st);
    case (st)
      ST_NORMAL:          return IMG_NORMAL;
      ST_TRIGGERED:       return IMG_TRIGGERED;
      ST_ACTIVE_HYPO:     return IMG_ACTIVE_HYPO;
      ST_ACTIVE_PIT:      return IMG_ACTIVE_PIT;
      ST_NO_THYROID:      return IMG_NO_THYROID;
      ST_MEDICATED:       return IMG_MEDICATED;
      ST_REESTABLISHMENT: return IMG_REESTABLISHMENT;
      default:            return IMG_NONE;
    endcase
  endfunction

  function automatic logic [1:0] state_to_resp(input logic [2:0] st);
    case (st)
      ST_NORMAL:          return RESP_HEALTHY;
      ST_REESTABLISHMENT: return RESP_HEALTHY;
      default:            return RESP_LOW;
    endcase
  endfunction

endpackage

// File: rtl/hpt_evt_fifo.sv
// First-word-fall-through record FIFO; pointers carry an extra wrap bit to tell full from empty.
module hpt_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop_s;
  logic             do_push_s;

  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop_s  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves at the same edge.
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign data_o    = empty_o ? {WIDTH{1'b0}} : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q                <= wr_q + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_q <= rd_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/hpt_status_decoder.sv
// HPT status bus receiver: timestamps state transitions into a record FIFO.
// Optional consistency checker enabled by defining HPT_DECODE_CHECK_EN.
module hpt_status_decoder
  import hpt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DWELL_W    = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [7:0]           data_hypo,
  input  logic [9:0]           image_hypo,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [6+DWELL_W-1:0] evt_data,
  output logic [2:0]           cur_state,
  output logic [2:0]           hormones,
  output logic                 evt_ovf,
  output logic                 err_image,
  output logic                 err_resp,
  output logic                 err_state
);

  localparam int REC_W = 6 + DWELL_W;
  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [2:0]         state_q;
  logic [2:0]         hormones_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_d;
  logic               ovf_q;
  logic [2:0]         new_state_s;
  logic               change_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  hpt_evt_t           hdr_s;
  logic [REC_W-1:0]   rec_s;

  assign new_state_s    = data_hypo[7:5];
  assign change_s       = (new_state_s != state_q);
  assign hdr_s.from_state = state_q;
  assign hdr_s.to_state   = new_state_s;
  assign rec_s          = {hdr_s, dwell_q};
  assign evt_valid      = !empty_s;
  assign pop_s          = evt_valid && evt_ready;

  hpt_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (change_s),
    .data_i  (rec_s),
    .pop_i   (pop_s),
    .data_o  (evt_data),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Dwell restarts on a transition and otherwise counts up, sticking at all-ones.
  always_comb begin
    dwell_d = dwell_q;
    if (change_s) begin
      dwell_d = {DWELL_W{1'b0}};
    end else if (&dwell_q) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + DWELL_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= 3'd0;
      hormones_q <= 3'd0;
      dwell_q    <= {DWELL_W{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= new_state_s;
      hormones_q <= data_hypo[2:0];
      dwell_q    <= dwell_d;
      ovf_q      <= ovf_q | (change_s && full_s && !pop_s);
    end
  end

  assign cur_state = state_q;
  assign hormones  = hormones_q;
  assign evt_ovf   = ovf_q;

`ifdef HPT_DECODE_CHECK_EN
  logic chk_armed_q;
  logic err_image_q;
  logic err_resp_q;
  logic err_state_q;

  // Image and response lag the state by one cycle, so they are checked against state_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chk_armed_q <= 1'b0;
      err_image_q <= 1'b0;
      err_resp_q  <= 1'b0;
      err_state_q <= 1'b0;
    end else begin
      chk_armed_q <= 1'b1;
      err_image_q <= err_image_q | (chk_armed_q && (image_hypo != state_to_image(state_q)));
      err_resp_q  <= err_resp_q  | (chk_armed_q && (data_hypo[4:3] != state_to_resp(state_q)));
      err_state_q <= err_state_q | (new_state_s == ST_ILLEGAL);
    end
  end

  assign err_image = err_image_q;
  assign err_resp  = err_resp_q;
  assign err_state = err_state_q;
`else
  logic unused_chk_s;
  assign unused_chk_s = ^{image_hypo, data_hypo[4:3]};
  assign err_image    = 1'b0;
  assign err_resp     = 1'b0;
  assign err_state    = 1'b0;
`endif

endmodule
